// File: rtl/burst_seq_gen.sv
// Purpose: drives b high for B_LEN cycles then pulses c once, on each accepted rising edge of a.
// Latency: first b one cycle after the rising edge is sampled; c follows the last b cycle.
// Backpressure: none; triggers during a burst are dropped and counted (retriggered with BURST_SEQ_GEN_RETRIG_EN).
module burst_seq_gen #(
    parameter int B_LEN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    localparam int              CW   = $clog2(B_LEN + 1);
    localparam logic [CW-1:0]   LAST = CW'(B_LEN);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_TERM  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic            r_a_q;
    logic            r_b;
    logic            w_b;
    logic            r_c;
    logic            w_c;
    logic            r_busy;
    logic            w_busy;
    logic [7:0]      r_ovr;
    logic [7:0]      w_ovr;
    logic            w_rise;

    // a_q resets low, so a trigger held high through reset counts as a rise on the first edge
    assign w_rise = a & ~r_a_q;

    assign b           = r_b;
    assign c           = r_c;
    assign busy        = r_busy;
    assign overrun_cnt = r_ovr;

    // State, counter, registered outputs and the trigger history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a_q   <= 1'b0;
            r_b     <= 1'b0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 8'd0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_a_q   <= a;
            r_b     <= w_b;
            r_c     <= w_c;
            r_busy  <= w_busy;
            r_ovr   <= w_ovr;
        end
    end

    // Next-state and next-output decode; c is a one-cycle pulse so it defaults low
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_b     = r_b;
        w_c     = 1'b0;
        w_busy  = r_busy;
        w_ovr   = r_ovr;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state = S_BURST;
                    w_cnt   = ONE;
                    w_b     = 1'b1;
                    w_busy  = 1'b1;
                end else begin
                    w_b     = 1'b0;
                    w_busy  = 1'b0;
                end
            end
            S_BURST: begin
                w_busy = 1'b1;
                // A trigger landing mid-burst is always an overrun, including on the final b edge
                if (w_rise && (r_ovr != 8'hFF)) begin
                    w_ovr = r_ovr + 8'd1;
                end
`ifdef BURST_SEQ_GEN_RETRIG_EN
                // Retrigger wins over the TERM transition, stretching b with no gap
                if (w_rise) begin
                    w_cnt = ONE;
                    w_b   = 1'b1;
                end else
`endif
                if (r_cnt == LAST) begin
                    w_state = S_TERM;
                    w_b     = 1'b0;
                    w_c     = 1'b1;
                end else begin
                    w_cnt   = r_cnt + ONE;
                    w_b     = 1'b1;
                end
            end
            S_TERM: begin
                // A rise on the c edge is accepted back-to-back; b rises the cycle after c
                if (w_rise) begin
                    w_state = S_BURST;
                    w_cnt   = ONE;
                    w_b     = 1'b1;
                    w_busy  = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_b     = 1'b0;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_b     = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/burst_seq_gen.md
# burst_seq_gen

Stimulus-side sequence generator for the `$rose(a) |-> ##1 b[*N] ##1 c` handshake. On a sampled rising edge of trigger `a`, it drives `b` high for exactly `B_LEN` consecutive cycles, then pulses `c` for one cycle. It sits in the training/assertion environment as the driver that a concurrent consecutive-repetition checker observes. It also counts triggers that were dropped because they arrived mid-burst.

## Interface
- `B_LEN`, default 6: number of consecutive cycles `b` is high. Legal range 1..255.
- `clk` input 1: sole clock, all logic on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `a` input 1: trigger, sampled at posedge `clk`.
- `b` output 1: burst strobe, registered.
- `c` output 1: terminator pulse, registered.
- `busy` output 1: high while a sequence is in progress, registered.
- `overrun_cnt` output 8: saturating count of triggers that arrived during a burst.

## Operation
- Edge detect:
  - `a_q` is the register holding `a` from the previous edge. It resets to 0.
  - `rise = a & ~a_q`, evaluated at each posedge.
  - If `a` is high at the first edge after reset, that counts as a rise.
- States: IDLE, BURST, TERM. Encoding is free.
- Burst counter `cnt`: width `$clog2(B_LEN+1)`, reset 0.
- IDLE:
  - On `rise`: go to BURST with `b<=1`, `busy<=1`, `cnt<=1`.
  - Otherwise stay in IDLE with `b=c=busy=0`.
- BURST:
  - If `cnt==B_LEN`: go to TERM with `b<=0`, `c<=1`.
  - Otherwise: `cnt<=cnt+1`, `b` stays 1.
- TERM:
  - Always `c<=0`.
  - On `rise`: go directly to BURST with `b<=1`, `busy<=1`, `cnt<=1`. This is back-to-back acceptance.
  - Otherwise go to IDLE with `busy<=0`.
- `rise` while in BURST:
  - The trigger is dropped and the sequence continues unchanged.
  - `overrun_cnt` increments and saturates at 255 (no wrap).
  - When `rise` coincides with the `cnt==B_LEN` edge, the trigger still counts as an overrun. The transition to TERM still occurs.
- `B_LEN==1`: BURST lasts one cycle. The counter compare must handle this case.
- Invariant: `b` and `c` are never high in the same cycle.

## Timing
- Reset values: `b=0`, `c=0`, `busy=0`, `overrun_cnt=0`, state IDLE, `cnt=0`, `a_q=0`.
- When `rst_n` asserts mid-sequence, all outputs clear immediately (asynchronously). On release the block starts in IDLE.
- Rise sampled at edge t:
  - `b` is sampled high at edges t+1 … t+B_LEN.
  - `c` is sampled high at edge t+B_LEN+1.
  - `b` is sampled low at edge t+B_LEN+1.
  - `busy` is sampled high at edges t+1 … t+B_LEN+1.
- Latency from trigger sample to first `b` is one cycle. This satisfies `##1` in the checker.
- Earliest next accepted trigger is at edge t+B_LEN+1, the TERM edge. An accepted TERM trigger puts `b` high at t+B_LEN+2, so `c` and the new `b` never overlap.
- `overrun_cnt` updates one cycle after the offending edge.

## Configuration
- Macro `BURST_SEQ_GEN_RETRIG_EN`:
  - Defined: a `rise` in BURST restarts the burst with `cnt<=1`. `b` stays high with no gap, so `b` is high for B_LEN cycles after the last trigger. `overrun_cnt` still increments.
  - Undefined: mid-burst triggers are dropped as described under Operation.
- Retrigger on the `cnt==B_LEN` edge takes priority over the TERM transition, so `c` is not asserted.

## Test plan
- Reset release, `a` low for 2 edges, then `a=1` held. Required: `b` high for exactly 6 edges starting 1 edge after the rise, `c` high for 1 edge, `busy` falls after the `c` edge. A bound checker for `$rose(a) |-> ##1 b[*6] ##1 c` passes.
- Second rise 3 edges into a burst (macro off). Required: burst unchanged, 6 `b` cycles, `overrun_cnt==1`.
- Same stimulus with `BURST_SEQ_GEN_RETRIG_EN`. Required: `b` high for 3+6=9 consecutive edges, then `c`, `overrun_cnt==1`.
- Rise on the TERM edge. Required: `c` for 1 edge, then immediately 6 more `b` edges, `busy` continuous, `b&c` never true.
- `rst_n` pulsed low at burst cycle 4. Required: `b`, `c`, `busy` drop to 0 during reset. A rise after release produces a full 6-cycle burst.
- 300 mid-burst triggers, one per burst, with `B_LEN=2`. Required: `overrun_cnt` saturates at 255 and stays there.
